// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor
//   Receive-side checker for a VGA sync stream (h_sync, v_sync, bright).
//   Measures line and frame timing against the expected geometry, recovers
//   pixel x/y coordinates, reports lock and keeps sticky error flags.
//
// Ports
//   clk_50        in   system clock (all inputs are in this domain)
//   n_reset       in   synchronous active-low reset
//   pix_en        in   pixel strobe; stream inputs are sampled only when high
//   h_sync        in   horizontal sync, active low
//   v_sync        in   vertical sync, active low
//   bright        in   active-video enable
//   err_clr       in   one-cycle pulse clearing err (a new error in the same cycle wins)
//   pix_valid     out  x/y valid for one cycle per bright sample while locked
//   x, y          out  pixel column / row of the last valid pixel
//   locked        out  geometry matched for LOCK_FRAMES consecutive frames
//   err           out  sticky: [0] h_total [1] h_pw [2] h_active [3] v_total/v_pw/v_active
//   h_total_meas  out  last complete line length in pixels (saturating)
//   v_total_meas  out  last complete frame length in lines (saturating)
module vga_timing_monitor #(
    parameter int H_TOTAL     = 800,
    parameter int H_PW        = 96,
    parameter int H_ACTIVE    = 640,
    parameter int V_TOTAL     = 521,
    parameter int V_PW        = 2,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk_50,
    input  logic       n_reset,
    input  logic       pix_en,
    input  logic       h_sync,
    input  logic       v_sync,
    input  logic       bright,
    input  logic       err_clr,
    output logic       pix_valid,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       locked,
    output logic [3:0] err,
    output logic [9:0] h_total_meas,
    output logic [9:0] v_total_meas
);

    localparam logic [9:0] H_TOTAL_C  = 10'(H_TOTAL);
    localparam logic [9:0] H_PW_C     = 10'(H_PW);
    localparam logic [9:0] H_ACTIVE_C = 10'(H_ACTIVE);
    localparam logic [9:0] V_TOTAL_C  = 10'(V_TOTAL);
    localparam logic [9:0] V_PW_C     = 10'(V_PW);
    localparam logic [9:0] V_ACTIVE_C = 10'(V_ACTIVE);
    localparam logic [3:0] LOCK_C     = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {ACQUIRE, CHECK, LOCKED} state_t;

    state_t     state, state_nxt;
    logic [3:0] good_cnt, good_cnt_nxt;

    logic       h_prev, b_prev;
    logic       v_line;             // v_sync as sampled at the previous line start
    logic [9:0] h_cnt, hpw_cnt, hact_cnt;
    logic [9:0] v_cnt, vpw_cnt, vact_cnt;
    logic       frame_bad;
    logic [9:0] x_cnt;
    logic [8:0] y_cnt;

    logic       line_start, frame_start, checking, line_has_bright;
    logic [2:0] h_err;
    logic       v_err, frame_good;
    logic [9:0] vact_frame;
    logic [3:0] new_err;
    logic [9:0] x_cur;
    logic [8:0] y_cur;
    logic       pix_hit;

    function automatic logic [9:0] inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    function automatic logic [8:0] inc9(input logic [8:0] v);
        return (v == 9'h1FF) ? v : v + 9'd1;
    endfunction

    assign line_start      = pix_en & h_prev & ~h_sync;
    assign frame_start     = line_start & v_line & ~v_sync;
    assign checking        = (state != ACQUIRE);
    assign line_has_bright = (hact_cnt != 10'd0);

    // Counters hold the line that ends at this line-start sample.
    assign h_err[0] = (h_cnt != H_TOTAL_C);
    assign h_err[1] = (hpw_cnt != H_PW_C);
    assign h_err[2] = line_has_bright && (hact_cnt != H_ACTIVE_C);

    // The line closing at the frame start still belongs to the old frame.
    assign vact_frame = line_has_bright ? inc10(vact_cnt) : vact_cnt;
    assign v_err      = (v_cnt != V_TOTAL_C) || (vpw_cnt != V_PW_C) ||
                        (vact_frame != V_ACTIVE_C);
    assign frame_good = !frame_bad && (h_err == 3'b000) && !v_err;

    assign new_err[2:0] = (line_start && checking) ? h_err : 3'b000;
    assign new_err[3]   = frame_start && checking && v_err;

    assign x_cur   = line_start  ? 10'd0 : x_cnt;
    assign y_cur   = frame_start ? 9'd0  : y_cnt;
    assign pix_hit = pix_en & bright & (state == LOCKED);

    assign locked = (state == LOCKED);

    always_comb begin
        state_nxt    = state;
        good_cnt_nxt = good_cnt;
        if (frame_start) begin
            case (state)
                ACQUIRE: begin
                    state_nxt    = CHECK;
                    good_cnt_nxt = 4'd0;
                end
                CHECK: begin
                    if (frame_good) begin
                        good_cnt_nxt = good_cnt + 4'd1;
                        if (good_cnt + 4'd1 == LOCK_C)
                            state_nxt = LOCKED;
                    end else begin
                        good_cnt_nxt = 4'd0;
                    end
                end
                LOCKED: begin
                    if (!frame_good) begin
                        state_nxt    = CHECK;
                        good_cnt_nxt = 4'd0;
                    end
                end
                default: begin
                    state_nxt    = ACQUIRE;
                    good_cnt_nxt = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_50) begin
        if (!n_reset) begin
            state        <= ACQUIRE;
            good_cnt     <= 4'd0;
            h_prev       <= 1'b0;
            b_prev       <= 1'b0;
            v_line       <= 1'b0;
            h_cnt        <= 10'd0;
            hpw_cnt      <= 10'd0;
            hact_cnt     <= 10'd0;
            v_cnt        <= 10'd0;
            vpw_cnt      <= 10'd0;
            vact_cnt     <= 10'd0;
            frame_bad    <= 1'b0;
            x_cnt        <= 10'd0;
            y_cnt        <= 9'd0;
            pix_valid    <= 1'b0;
            x            <= 10'd0;
            y            <= 9'd0;
            err          <= 4'd0;
            h_total_meas <= 10'd0;
            v_total_meas <= 10'd0;
        end else begin
            state     <= state_nxt;
            good_cnt  <= good_cnt_nxt;
            err       <= (err & ~{4{err_clr}}) | new_err;
            pix_valid <= pix_hit;
            if (pix_hit) begin
                x <= x_cur;
                y <= y_cur;
            end
            if (pix_en) begin
                h_prev <= h_sync;
                b_prev <= bright;
                x_cnt  <= bright ? inc10(x_cur) : x_cur;
                // Row advances at the end of each active run.
                y_cnt  <= (b_prev & ~bright) ? inc9(y_cur) : y_cur;
                if (line_start) begin
                    v_line       <= v_sync;
                    h_cnt        <= 10'd1;
                    hpw_cnt      <= 10'd1;
                    hact_cnt     <= {9'd0, bright};
                    h_total_meas <= h_cnt;
                    if (frame_start) begin
                        v_cnt        <= 10'd1;
                        vpw_cnt      <= 10'd1;
                        vact_cnt     <= 10'd0;
                        v_total_meas <= v_cnt;
                        frame_bad    <= 1'b0;
                    end else begin
                        v_cnt <= inc10(v_cnt);
                        if (!v_sync)
                            vpw_cnt <= inc10(vpw_cnt);
                        if (line_has_bright)
                            vact_cnt <= inc10(vact_cnt);
                        if (checking && (h_err != 3'b000))
                            frame_bad <= 1'b1;
                    end
                end else begin
                    h_cnt <= inc10(h_cnt);
                    if (!h_sync)
                        hpw_cnt <= inc10(hpw_cnt);
                    if (bright)
                        hact_cnt <= inc10(hact_cnt);
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor using a reduced raster
// (20 pixels x 10 lines, 8x4 active) so whole frames stay short.
module tb_vga_timing_monitor;

    localparam int HT = 20, HPW = 3, HA = 8, HBP = 4;
    localparam int VT = 10, VPW = 2, VA = 4, VBP = 2;
    localparam int BSTART = HPW + HBP;   // first bright pixel in a line
    localparam int ASTART = VPW + VBP;   // first active line in a frame

    logic       clk_50 = 1'b0;
    logic       n_reset, pix_en, h_sync, v_sync, bright, err_clr;
    logic       pix_valid, locked;
    logic [9:0] x, h_total_meas, v_total_meas;
    logic [8:0] y;
    logic [3:0] err;

    int checks = 0;
    int failures = 0;
    logic [18:0] pv_log[$];

    vga_timing_monitor #(
        .H_TOTAL(HT), .H_PW(HPW), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_PW(VPW), .V_ACTIVE(VA), .LOCK_FRAMES(2)
    ) dut (
        .clk_50(clk_50), .n_reset(n_reset), .pix_en(pix_en),
        .h_sync(h_sync), .v_sync(v_sync), .bright(bright), .err_clr(err_clr),
        .pix_valid(pix_valid), .x(x), .y(y), .locked(locked), .err(err),
        .h_total_meas(h_total_meas), .v_total_meas(v_total_meas)
    );

    always #5 clk_50 = ~clk_50;

    always @(negedge clk_50)
        if (pix_valid) pv_log.push_back({y, x});

    task automatic pixel(input logic h, input logic v, input logic b, input logic clr);
        @(negedge clk_50);
        h_sync = h; v_sync = v; bright = b; err_clr = clr; pix_en = 1'b1;
        @(negedge clk_50);
        pix_en = 1'b0; err_clr = 1'b0;
    endtask

    task automatic send_line(input int htot, input int hpw, input int hact,
                             input logic vlow, input logic act, input logic clr);
        for (int i = 0; i < htot; i++)
            pixel(i >= hpw, ~vlow, act && i >= BSTART && i < BSTART + hact, clr && i == 0);
    endtask

    task automatic send_frame(input int vpw, input int bad_line, input int bad_htot,
                              input int bad_hpw, input int bad_hact, input int clr_line);
        for (int j = 0; j < VT; j++)
            send_line(j == bad_line ? bad_htot : HT, j == bad_line ? bad_hpw : HPW,
                      j == bad_line ? bad_hact : HA, j < vpw,
                      j >= ASTART && j < ASTART + VA, j == clr_line);
    endtask

    task automatic nominal_frame();
        send_frame(VPW, -1, HT, HPW, HA, -1);
    endtask

    task automatic pulse_clr();
        @(negedge clk_50); err_clr = 1'b1;
        @(negedge clk_50); err_clr = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if (pix_valid !== 1'b0 || x !== 10'd0 || y !== 9'd0 || locked !== 1'b0) begin
            failures++;
            $display("FAIL %s_pix got pv=%b x=%0d y=%0d lk=%b exp all 0", tag, pix_valid, x, y, locked);
        end
        checks++;
        if (err !== 4'd0) begin failures++; $display("FAIL %s_err got=%b exp=0000", tag, err); end
        checks++;
        if (h_total_meas !== 10'd0 || v_total_meas !== 10'd0) begin
            failures++;
            $display("FAIL %s_meas got h=%0d v=%0d exp 0 0", tag, h_total_meas, v_total_meas);
        end
    endtask

    task automatic test_reset();
        n_reset = 1'b0; pix_en = 1'b0; h_sync = 1'b1; v_sync = 1'b1; bright = 1'b0; err_clr = 1'b0;
        repeat (4) @(negedge clk_50);
        check_zero("reset");
        n_reset = 1'b1;
        repeat (3) pixel(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_lock();
        repeat (3) nominal_frame();
        checks++;
        if (locked !== 1'b0) begin failures++; $display("FAIL lock_early got=%b exp=0", locked); end
        nominal_frame();
        checks++;
        if (locked !== 1'b1) begin failures++; $display("FAIL lock_set got=%b exp=1", locked); end
        checks++;
        if (err !== 4'd0) begin failures++; $display("FAIL lock_err got=%b exp=0000", err); end
        checks++;
        if (h_total_meas !== 10'd20) begin failures++; $display("FAIL lock_hmeas got=%0d exp=20", h_total_meas); end
        checks++;
        if (v_total_meas !== 10'd10) begin failures++; $display("FAIL lock_vmeas got=%0d exp=10", v_total_meas); end
    endtask

    task automatic test_raster();
        int bad;
        logic [18:0] exp;
        pv_log.delete();
        nominal_frame();
        checks++;
        if (pv_log.size() != HA * VA) begin
            failures++; $display("FAIL raster_count got=%0d exp=%0d", pv_log.size(), HA * VA);
        end else begin
            checks++;
            if (pv_log[0] !== 19'd0) begin failures++; $display("FAIL raster_first got=%h exp=0", pv_log[0]); end
            exp = {9'd3, 10'd7};
            checks++;
            if (pv_log[$] !== exp) begin failures++; $display("FAIL raster_last got=%h exp=%h", pv_log[$], exp); end
            bad = 0;
            for (int k = 0; k < HA * VA; k++) begin
                exp = {9'(k / HA), 10'(k % HA)};
                if (pv_log[k] !== exp) bad++;
            end
            checks++;
            if (bad != 0) begin failures++; $display("FAIL raster_order got=%0d bad entries exp=0", bad); end
        end
        checks++;
        if (x !== 10'd7 || y !== 9'd3 || pix_valid !== 1'b0) begin
            failures++; $display("FAIL raster_hold got x=%0d y=%0d pv=%b exp 7 3 0", x, y, pix_valid);
        end
    endtask

    task automatic test_stretch();
        send_frame(VPW, 5, HT + 1, HPW, HA, -1);
        checks++;
        if (err !== 4'b0001) begin failures++; $display("FAIL stretch_err got=%b exp=0001", err); end
        checks++;
        if (locked !== 1'b1) begin failures++; $display("FAIL stretch_hold got=%b exp=1", locked); end
        nominal_frame();
        checks++;
        if (locked !== 1'b0) begin failures++; $display("FAIL stretch_drop got=%b exp=0", locked); end
        nominal_frame();
        checks++;
        if (locked !== 1'b0) begin failures++; $display("FAIL stretch_one got=%b exp=0", locked); end
        nominal_frame();
        checks++;
        if (locked !== 1'b1) begin failures++; $display("FAIL stretch_relock got=%b exp=1", locked); end
        checks++;
        if (err !== 4'b0001) begin failures++; $display("FAIL stretch_sticky got=%b exp=0001", err); end
    endtask

    task automatic test_sync_width();
        pulse_clr();
        checks++;
        if (err !== 4'b0000) begin failures++; $display("FAIL clr_plain got=%b exp=0000", err); end
        send_frame(3, 3, HT, HPW - 1, HA, -1);
        checks++;
        if (err !== 4'b0010) begin failures++; $display("FAIL hpw_err got=%b exp=0010", err); end
        nominal_frame();
        checks++;
        if (err !== 4'b1010) begin failures++; $display("FAIL vpw_err got=%b exp=1010", err); end
        checks++;
        if (locked !== 1'b0) begin failures++; $display("FAIL vpw_drop got=%b exp=0", locked); end
        // Short active run on line 4 is detected at line 5 start, together with err_clr.
        send_frame(VPW, 4, HT, HPW, HA - 1, 5);
        checks++;
        if (err !== 4'b0100) begin failures++; $display("FAIL clr_setwins got=%b exp=0100", err); end
        pulse_clr();
        checks++;
        if (err !== 4'b0000) begin failures++; $display("FAIL clr_final got=%b exp=0000", err); end
    endtask

    task automatic test_reset_mid();
        send_line(HT, HPW, HA, 1'b1, 1'b0, 1'b0);
        send_line(HT, HPW, HA, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) pixel(i >= HPW, 1'b1, 1'b0, 1'b0);
        @(negedge clk_50); n_reset = 1'b0;
        @(negedge clk_50); n_reset = 1'b1;
        check_zero("midreset");
        for (int i = 10; i < HT; i++) pixel(1'b1, 1'b1, 1'b0, 1'b0);
        for (int j = 3; j < VT; j++)
            send_line(HT, HPW, HA, 1'b0, j >= ASTART && j < ASTART + VA, 1'b0);
        checks++;
        if (err !== 4'd0 || locked !== 1'b0) begin
            failures++; $display("FAIL partial_line got err=%b lk=%b exp 0000 0", err, locked);
        end
        nominal_frame();
        nominal_frame();
        checks++;
        if (locked !== 1'b0) begin failures++; $display("FAIL relock_early got=%b exp=0", locked); end
        nominal_frame();
        checks++;
        if (locked !== 1'b1 || err !== 4'd0) begin
            failures++; $display("FAIL relock got lk=%b err=%b exp 1 0000", locked, err);
        end
        checks++;
        if (v_total_meas !== 10'd10) begin failures++; $display("FAIL relock_vmeas got=%0d exp=10", v_total_meas); end
    endtask

    task automatic test_stuck();
        repeat (2000) pixel(1'b1, 1'b1, 1'b0, 1'b0);
        pixel(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (h_total_meas !== 10'd1023) begin failures++; $display("FAIL stuck_meas got=%0d exp=1023", h_total_meas); end
        checks++;
        if (err !== 4'b0001) begin failures++; $display("FAIL stuck_err got=%b exp=0001", err); end
        checks++;
        if (locked !== 1'b0) begin failures++; $display("FAIL stuck_drop got=%b exp=0", locked); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_raster();
        test_stretch();
        test_sync_width();
        test_reset_mid();
        test_stuck();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
